// File: rtl/window_peak_tracker.sv
// window_peak_tracker
// Tracks the largest signed sample, with its timestamp and a sample count,
// over each search window marked by i_active. The result of each window is
// held for a valid/ready consumer. A window that starts while a result is
// still held is dropped and flagged with a single o_drop pulse.

module window_peak_tracker #(
    parameter int DATA_WIDTH = 16,
    parameter int CTR_WIDTH  = 22,
    parameter int NCNT_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic                  i_ce,
    input  logic [DATA_WIDTH-1:0] i_sample,
    input  logic [CTR_WIDTH-1:0]  i_ctr,
    input  logic                  i_active,
    output logic [DATA_WIDTH-1:0] o_peak,
    output logic [CTR_WIDTH-1:0]  o_peak_time,
    output logic [NCNT_WIDTH-1:0] o_count,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_drop
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
    localparam logic [CTR_WIDTH-1:0]  CTR_ZERO  = {CTR_WIDTH{1'b0}};
    localparam logic [NCNT_WIDTH-1:0] CNT_ZERO  = {NCNT_WIDTH{1'b0}};
    localparam logic [NCNT_WIDTH-1:0] CNT_ONE   = {{(NCNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [NCNT_WIDTH-1:0] CNT_MAX   = {NCNT_WIDTH{1'b1}};

    // Count increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [NCNT_WIDTH-1:0] sat_inc(input logic [NCNT_WIDTH-1:0] v);
        logic [NCNT_WIDTH-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    state_t                  state_r;
    state_t                  state_next_s;
    logic                    active_d_r;
    logic                    rise_s;
    logic                    fall_s;
    logic                    start_s;
    logic                    take_s;
    logic                    load_s;
    logic                    release_s;
    logic                    drop_s;
    logic                    new_max_s;
    logic [DATA_WIDTH-1:0]   max_r;
    logic [CTR_WIDTH-1:0]    time_r;
    logic [NCNT_WIDTH-1:0]   cnt_r;

    assign rise_s = i_active & ~active_d_r;
    assign fall_s = ~i_active & active_d_r;

    // Delayed copy of the window level for edge detection.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            active_d_r <= 1'b0;
        end else begin
            active_d_r <= i_active;
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; a held result blocks new windows until it is accepted.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (rise_s) begin
                    state_next_s = ST_TRACK;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_TRACK: begin
                if (fall_s) begin
                    if (cnt_r != CNT_ZERO) begin
                        state_next_s = ST_HOLD;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    state_next_s = ST_TRACK;
                end
            end
            ST_HOLD: begin
                if (i_ready) begin
                    if (rise_s) begin
                        state_next_s = ST_TRACK;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Per-state control strobes driving the datapath and output registers.
    always_comb begin
        start_s   = 1'b0;
        take_s    = 1'b0;
        load_s    = 1'b0;
        release_s = 1'b0;
        drop_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                start_s = rise_s;
            end
            ST_TRACK: begin
                take_s = i_ce & i_active & ~fall_s;
                load_s = fall_s & (cnt_r != CNT_ZERO);
            end
            ST_HOLD: begin
                release_s = i_ready;
                start_s   = i_ready & rise_s;
                drop_s    = ~i_ready & rise_s;
            end
            default: begin
                start_s = 1'b0;
            end
        endcase
    end

    // The first sample of a window always wins, so an all-minimum window still
    // records the timestamp of its first sample; afterwards only a strictly
    // larger sample replaces the peak, keeping the earliest of equal values.
    assign new_max_s = (cnt_r == CNT_ZERO) || ($signed(i_sample) > $signed(max_r));

    // Running peak, its timestamp and the sample count of the open window.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            max_r  <= DATA_ZERO;
            time_r <= CTR_ZERO;
            cnt_r  <= CNT_ZERO;
        end else if (start_s) begin
            if (i_ce) begin
                max_r  <= i_sample;
                time_r <= i_ctr;
                cnt_r  <= CNT_ONE;
            end else begin
                max_r  <= MOST_NEG;
                time_r <= time_r;
                cnt_r  <= CNT_ZERO;
            end
        end else if (take_s) begin
            cnt_r <= sat_inc(cnt_r);
            if (new_max_s) begin
                max_r  <= i_sample;
                time_r <= i_ctr;
            end else begin
                max_r  <= max_r;
                time_r <= time_r;
            end
        end else begin
            max_r  <= max_r;
            time_r <= time_r;
            cnt_r  <= cnt_r;
        end
    end

    // Result registers: loaded only when a non-empty window closes.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            o_peak      <= DATA_ZERO;
            o_peak_time <= CTR_ZERO;
            o_count     <= CNT_ZERO;
            o_valid     <= 1'b0;
        end else if (load_s) begin
            o_peak      <= max_r;
            o_peak_time <= time_r;
            o_count     <= cnt_r;
            o_valid     <= 1'b1;
        end else if (release_s) begin
            o_valid     <= 1'b0;
        end else begin
            o_valid     <= o_valid;
        end
    end

    // One-cycle flag for a window lost behind an unaccepted result.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            o_drop <= 1'b0;
        end else begin
            o_drop <= drop_s;
        end
    end

endmodule

// File: tb/tb_window_peak_tracker.sv
// Bench for window_peak_tracker: a fixed vector table, hand-written reset and
// saturation sequences, and randomized traffic checked against a queue-based
// reference model that computes each window's peak from its collected samples.

module tb_window_peak_tracker;

    localparam int DW = 16;
    localparam int CW = 22;
    localparam int NW = 8;

    logic          i_clk = 1'b0;
    logic          i_nrst = 1'b1;
    logic          i_ce = 1'b0;
    logic [DW-1:0] i_sample = '0;
    logic [CW-1:0] i_ctr = '0;
    logic          i_active = 1'b0;
    logic          i_ready = 1'b0;
    logic [DW-1:0] o_peak;
    logic [CW-1:0] o_peak_time;
    logic [NW-1:0] o_count;
    logic          o_valid;
    logic          o_drop;

    always #5 i_clk = ~i_clk;

    window_peak_tracker #(.DATA_WIDTH(DW), .CTR_WIDTH(CW), .NCNT_WIDTH(NW)) dut (
        .i_clk(i_clk), .i_nrst(i_nrst), .i_ce(i_ce), .i_sample(i_sample),
        .i_ctr(i_ctr), .i_active(i_active), .o_peak(o_peak),
        .o_peak_time(o_peak_time), .o_count(o_count), .o_valid(o_valid),
        .i_ready(i_ready), .o_drop(o_drop)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: samples of the open window are simply collected.
    typedef struct packed {
        logic [DW-1:0] s;
        logic [CW-1:0] t;
    } samp_t;
    samp_t q[$];
    bit m_act_d, m_trk, m_hold;
    logic [DW-1:0] e_peak;
    logic [CW-1:0] e_time;
    logic [NW-1:0] e_cnt;
    bit e_valid, e_drop;

    typedef struct {
        logic ce; logic [DW-1:0] s; logic [CW-1:0] t; logic act; logic rdy;
        logic ev; logic [DW-1:0] ep; logic [CW-1:0] et; logic [NW-1:0] ec; logic ed;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_act_d = 1'b0; m_trk = 1'b0; m_hold = 1'b0;
        e_peak = '0; e_time = '0; e_cnt = '0; e_valid = 1'b0; e_drop = 1'b0;
    endtask

    task automatic open_window(input logic ce, input logic [DW-1:0] s, input logic [CW-1:0] t);
        samp_t e;
        m_trk = 1'b1;
        q.delete();
        if (ce) begin
            e.s = s; e.t = t;
            q.push_back(e);
        end
    endtask

    task automatic close_window();
        int best = 0;
        for (int i = 1; i < q.size(); i++) begin
            if ($signed(q[i].s) > $signed(q[best].s)) best = i;
        end
        e_peak  = q[best].s;
        e_time  = q[best].t;
        e_cnt   = (q.size() > 255) ? 8'd255 : 8'(q.size());
        e_valid = 1'b1;
        m_hold  = 1'b1;
    endtask

    task automatic model_cycle(input logic ce, input logic [DW-1:0] s, input logic [CW-1:0] t,
                               input logic act, input logic rdy);
        bit rise, fall;
        samp_t e;
        rise = act && !m_act_d;
        fall = !act && m_act_d;
        e_drop = 1'b0;
        if (m_hold) begin
            if (rdy) begin
                m_hold = 1'b0;
                e_valid = 1'b0;
                if (rise) open_window(ce, s, t);
            end else if (rise) begin
                e_drop = 1'b1;
            end
        end else if (m_trk) begin
            if (fall) begin
                m_trk = 1'b0;
                if (q.size() > 0) close_window();
            end else if (ce) begin
                e.s = s; e.t = t;
                q.push_back(e);
            end
        end else if (rise) begin
            open_window(ce, s, t);
        end
        m_act_d = act;
    endtask

    task automatic step(input logic ce, input logic [DW-1:0] s, input logic [CW-1:0] t,
                        input logic act, input logic rdy);
        i_ce = ce; i_sample = s; i_ctr = t; i_active = act; i_ready = rdy;
        @(posedge i_clk);
        #1;
        model_cycle(ce, s, t, act, rdy);
        chk("valid", 32'(o_valid), 32'(e_valid));
        chk("drop", 32'(o_drop), 32'(e_drop));
        chk("peak", 32'(o_peak), 32'(e_peak));
        chk("peak_time", 32'(o_peak_time), 32'(e_time));
        chk("count", 32'(o_count), 32'(e_cnt));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 32'(o_valid), 32'd0);
        chk({tag, "_drop"}, 32'(o_drop), 32'd0);
        chk({tag, "_peak"}, 32'(o_peak), 32'd0);
        chk({tag, "_time"}, 32'(o_peak_time), 32'd0);
        chk({tag, "_count"}, 32'(o_count), 32'd0);
    endtask

    function automatic vec_t mk(input logic ce, input logic [DW-1:0] s, input logic [CW-1:0] t,
                                input logic act, input logic rdy, input logic ev,
                                input logic [DW-1:0] ep, input logic [CW-1:0] et,
                                input logic [NW-1:0] ec, input logic ed);
        vec_t v;
        v.ce = ce; v.s = s; v.t = t; v.act = act; v.rdy = rdy;
        v.ev = ev; v.ep = ep; v.et = et; v.ec = ec; v.ed = ed;
        return v;
    endfunction

    initial begin
        logic          act;
        logic [CW-1:0] ctr;
        logic [DW-1:0] smp;

        // Directed windows: basic peak, tie, empty window, all-minimum,
        // drop behind a held result, accept and rise in the same cycle.
        tbl.push_back(mk(1'b1, 16'sd5,    22'd100, 1'b1, 1'b0, 1'b0, 16'd0, 22'd0, 8'd0, 1'b0));
        tbl.push_back(mk(1'b1, -16'sd3,   22'd101, 1'b1, 1'b0, 1'b0, 16'd0, 22'd0, 8'd0, 1'b0));
        tbl.push_back(mk(1'b1, 16'sd9,    22'd102, 1'b1, 1'b0, 1'b0, 16'd0, 22'd0, 8'd0, 1'b0));
        tbl.push_back(mk(1'b1, 16'sd2,    22'd103, 1'b1, 1'b0, 1'b0, 16'd0, 22'd0, 8'd0, 1'b0));
        tbl.push_back(mk(1'b0, 16'sd0,    22'd104, 1'b0, 1'b1, 1'b1, 16'd9, 22'd102, 8'd4, 1'b0));
        tbl.push_back(mk(1'b0, 16'sd0,    22'd105, 1'b0, 1'b1, 1'b0, 16'd9, 22'd102, 8'd4, 1'b0));
        tbl.push_back(mk(1'b1, 16'sd7,    22'd10,  1'b1, 1'b0, 1'b0, 16'd9, 22'd102, 8'd4, 1'b0));
        tbl.push_back(mk(1'b1, 16'sd7,    22'd11,  1'b1, 1'b0, 1'b0, 16'd9, 22'd102, 8'd4, 1'b0));
        tbl.push_back(mk(1'b1, 16'sd7,    22'd12,  1'b1, 1'b0, 1'b0, 16'd9, 22'd102, 8'd4, 1'b0));
        tbl.push_back(mk(1'b1, 16'sd8,    22'd13,  1'b0, 1'b0, 1'b1, 16'd7, 22'd10, 8'd3, 1'b0));
        tbl.push_back(mk(1'b0, 16'sd0,    22'd14,  1'b0, 1'b1, 1'b0, 16'd7, 22'd10, 8'd3, 1'b0));
        tbl.push_back(mk(1'b0, 16'sd0,    22'd0,   1'b1, 1'b0, 1'b0, 16'd7, 22'd10, 8'd3, 1'b0));
        tbl.push_back(mk(1'b0, 16'sd0,    22'd0,   1'b1, 1'b0, 1'b0, 16'd7, 22'd10, 8'd3, 1'b0));
        tbl.push_back(mk(1'b0, 16'sd0,    22'd0,   1'b0, 1'b0, 1'b0, 16'd7, 22'd10, 8'd3, 1'b0));
        tbl.push_back(mk(1'b0, 16'sd0,    22'd0,   1'b0, 1'b0, 1'b0, 16'd7, 22'd10, 8'd3, 1'b0));
        tbl.push_back(mk(1'b1, 16'h8000,  22'd50,  1'b1, 1'b0, 1'b0, 16'd7, 22'd10, 8'd3, 1'b0));
        tbl.push_back(mk(1'b1, 16'h8000,  22'd51,  1'b1, 1'b0, 1'b0, 16'd7, 22'd10, 8'd3, 1'b0));
        tbl.push_back(mk(1'b0, 16'sd0,    22'd52,  1'b0, 1'b0, 1'b1, 16'h8000, 22'd50, 8'd2, 1'b0));
        tbl.push_back(mk(1'b0, 16'sd0,    22'd53,  1'b0, 1'b1, 1'b0, 16'h8000, 22'd50, 8'd2, 1'b0));
        tbl.push_back(mk(1'b1, 16'sd3,    22'd20,  1'b1, 1'b0, 1'b0, 16'h8000, 22'd50, 8'd2, 1'b0));
        tbl.push_back(mk(1'b0, 16'sd0,    22'd21,  1'b0, 1'b0, 1'b1, 16'd3, 22'd20, 8'd1, 1'b0));
        tbl.push_back(mk(1'b0, 16'sd0,    22'd22,  1'b0, 1'b0, 1'b1, 16'd3, 22'd20, 8'd1, 1'b0));
        tbl.push_back(mk(1'b1, 16'sd100,  22'd23,  1'b1, 1'b0, 1'b1, 16'd3, 22'd20, 8'd1, 1'b1));
        tbl.push_back(mk(1'b1, 16'sd100,  22'd24,  1'b1, 1'b0, 1'b1, 16'd3, 22'd20, 8'd1, 1'b0));
        tbl.push_back(mk(1'b0, 16'sd0,    22'd25,  1'b0, 1'b0, 1'b1, 16'd3, 22'd20, 8'd1, 1'b0));
        tbl.push_back(mk(1'b0, 16'sd0,    22'd26,  1'b0, 1'b1, 1'b0, 16'd3, 22'd20, 8'd1, 1'b0));
        tbl.push_back(mk(1'b0, 16'sd0,    22'd27,  1'b0, 1'b0, 1'b0, 16'd3, 22'd20, 8'd1, 1'b0));
        tbl.push_back(mk(1'b1, 16'sd4,    22'd30,  1'b1, 1'b0, 1'b0, 16'd3, 22'd20, 8'd1, 1'b0));
        tbl.push_back(mk(1'b0, 16'sd0,    22'd31,  1'b0, 1'b0, 1'b1, 16'd4, 22'd30, 8'd1, 1'b0));
        tbl.push_back(mk(1'b1, -16'sd5,   22'd32,  1'b1, 1'b1, 1'b0, 16'd4, 22'd30, 8'd1, 1'b0));
        tbl.push_back(mk(1'b1, -16'sd2,   22'd33,  1'b1, 1'b0, 1'b0, 16'd4, 22'd30, 8'd1, 1'b0));
        tbl.push_back(mk(1'b0, 16'sd0,    22'd34,  1'b0, 1'b0, 1'b1, -16'sd2, 22'd33, 8'd2, 1'b0));
        tbl.push_back(mk(1'b0, 16'sd0,    22'd35,  1'b0, 1'b1, 1'b0, -16'sd2, 22'd33, 8'd2, 1'b0));

        // Power-on reset.
        #1 i_nrst = 1'b0;
        #3;
        chk_zero("por");
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        i_nrst = 1'b1;
        model_reset();

        // Table vectors.
        foreach (tbl[i]) begin
            step(tbl[i].ce, tbl[i].s, tbl[i].t, tbl[i].act, tbl[i].rdy);
            chk($sformatf("tbl%0d_valid", i), 32'(o_valid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_peak", i), 32'(o_peak), 32'(tbl[i].ep));
            chk($sformatf("tbl%0d_time", i), 32'(o_peak_time), 32'(tbl[i].et));
            chk($sformatf("tbl%0d_count", i), 32'(o_count), 32'(tbl[i].ec));
            chk($sformatf("tbl%0d_drop", i), 32'(o_drop), 32'(tbl[i].ed));
        end

        // 300 strobes in one window: count saturates at 255.
        for (int k = 0; k < 300; k++) begin
            step(1'b1, 16'(k), 22'(1000 + k), 1'b1, 1'b0);
        end
        step(1'b0, 16'd0, 22'd2000, 1'b0, 1'b0);
        chk("sat_valid", 32'(o_valid), 32'd1);
        chk("sat_count", 32'(o_count), 32'd255);
        chk("sat_peak", 32'(o_peak), 32'd299);
        chk("sat_time", 32'(o_peak_time), 32'd1299);
        step(1'b0, 16'd0, 22'd2001, 1'b0, 1'b1);
        chk("sat_accept", 32'(o_valid), 32'd0);

        // Reset mid-TRACK: window discarded, outputs cleared at once.
        step(1'b1, 16'sd50, 22'd3000, 1'b1, 1'b0);
        step(1'b1, 16'sd60, 22'd3001, 1'b1, 1'b0);
        #2 i_nrst = 1'b0;
        #1;
        chk_zero("rst_track");
        model_reset();
        i_active = 1'b0;
        @(posedge i_clk); #1;
        i_nrst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 16'd0, 22'd3010, 1'b0, 1'b1);
            chk("rst_track_no_valid", 32'(o_valid), 32'd0);
        end

        // Reset mid-HOLD with the window level still high: first cycle after
        // release counts as a rise and a fresh window is tracked.
        step(1'b1, 16'sd11, 22'd60, 1'b1, 1'b0);
        step(1'b0, 16'd0, 22'd61, 1'b0, 1'b0);
        chk("hold_before_rst", 32'(o_valid), 32'd1);
        i_active = 1'b1;
        #2 i_nrst = 1'b0;
        #1;
        chk_zero("rst_hold");
        model_reset();
        @(posedge i_clk); #1;
        i_nrst = 1'b1;
        step(1'b1, 16'sd20, 22'd70, 1'b1, 1'b0);
        step(1'b1, -16'sd1, 22'd71, 1'b1, 1'b0);
        step(1'b0, 16'd0, 22'd72, 1'b0, 1'b0);
        chk("rel_valid", 32'(o_valid), 32'd1);
        chk("rel_peak", 32'(o_peak), 32'd20);
        chk("rel_time", 32'(o_peak_time), 32'd70);
        chk("rel_count", 32'(o_count), 32'd2);
        step(1'b0, 16'd0, 22'd73, 1'b0, 1'b1);

        // Randomized traffic against the model; the timestamp wraps.
        act = 1'b0;
        ctr = 22'h3FFF00;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) act = ~act;
            if ($urandom_range(0, 1) == 1) smp = 16'($urandom_range(0, 3));
            else smp = 16'($urandom);
            step(1'($urandom_range(0, 1)), smp, ctr, act, 1'($urandom_range(0, 2) == 0));
            ctr = ctr + 22'd1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/window_peak_tracker.md
WINDOW_PEAK_TRACKER -- requirements
Module: window_peak_tracker

Interface
REQ-001 Parameter DATA_WIDTH, default 16, sets the width of the signed sample.
REQ-002 Parameter CTR_WIDTH, default 22, sets the width of the free-running timestamp counter.
REQ-003 Parameter NCNT_WIDTH, default 8, sets the width of the per-window sample count.
REQ-004 Port i_clk, input, 1, is the single clock; all state updates on its rising edge.
REQ-005 Port i_nrst, input, 1, is the asynchronous active-low reset.
REQ-006 Port i_ce, input, 1, is the sample strobe; i_sample is valid only when it is 1.
REQ-007 Port i_sample, input, DATA_WIDTH, carries the signed two's-complement sample.
REQ-008 Port i_ctr, input, CTR_WIDTH, carries the free-running timestamp, shared with the window counter stage.
REQ-009 Port i_active, input, 1, is the search-window level from the upstream counter FSM.
REQ-010 Port o_peak, output, DATA_WIDTH, carries the maximum sample of the completed window.
REQ-011 Port o_peak_time, output, CTR_WIDTH, carries the i_ctr value at that maximum.
REQ-012 Port o_count, output, NCNT_WIDTH, carries the number of samples taken in the window.
REQ-013 Port o_valid, output, 1, flags a result held for the consumer.
REQ-014 Port i_ready, input, 1, is the consumer accept; a transfer occurs when o_valid and i_ready are both 1.
REQ-015 Port o_drop, output, 1, is a one-cycle pulse marking a window lost because a result was still held.

Function
REQ-016 The block SHALL register i_active into active_d and define rise = i_active & ~active_d and fall = ~i_active & active_d.
REQ-017 The state machine SHALL have three states: IDLE, TRACK and HOLD.
REQ-018 In IDLE on rise, the block SHALL enter TRACK, set max to the most negative value, and clear cnt to 0.
REQ-019 In the rise cycle with i_ce=1, that sample SHALL be taken as the first sample: max=i_sample, time=i_ctr, cnt=1.
REQ-020 In TRACK, on i_ce=1 with i_active=1, cnt SHALL increment, saturating at 2^NCNT_WIDTH-1.
REQ-021 In TRACK, on i_ce=1 with i_active=1 and i_sample > max (strict signed compare), max and time SHALL update; on ties the earliest timestamp is kept.
REQ-022 In TRACK on fall, a sample with i_ce=1 in that cycle SHALL be ignored because i_active=0.
REQ-023 In TRACK on fall with cnt=0, the block SHALL return to IDLE and produce no output.
REQ-024 In TRACK on fall with cnt>0, the block SHALL load o_peak/o_peak_time/o_count and set o_valid=1 on the next edge, entering HOLD; latency is 1 cycle after fall.
REQ-025 In HOLD, outputs SHALL stay stable and o_valid SHALL stay 1 until i_ready=1.
REQ-026 In HOLD with i_ready=1 and no rise, the block SHALL clear o_valid on the next edge and go to IDLE.
REQ-027 In HOLD with i_ready=1 and rise in the same cycle, the transfer SHALL complete and the block SHALL enter TRACK per REQ-018/019.
REQ-028 In HOLD with i_ready=0 and rise, o_drop SHALL pulse high for exactly one cycle on the next edge.
REQ-029 After a drop, the whole dropped window SHALL be ignored; after the transfer the block goes to IDLE and waits for a new rise.
REQ-030 i_ready SHALL be ignored outside HOLD.
REQ-031 i_ctr wrap-around SHALL need no special handling; the timestamp is captured raw.
REQ-032 o_peak, o_peak_time and o_count SHALL change only on entry to HOLD.

Reset
REQ-033 While i_nrst=0, asynchronously: state=IDLE, active_d=0, max=0, time=0, cnt=0, o_peak=0, o_peak_time=0, o_count=0, o_valid=0, o_drop=0.
REQ-034 A reset asserted mid-TRACK or mid-HOLD SHALL discard the window or result with no output.
REQ-035 After release with i_active already 1, active_d=0 makes the first cycle a rise, and tracking starts.

Verification
REQ-036 Window of 4 strobes with samples 5, -3, 9, 2 at i_ctr 100..103, i_ready=1 -> o_valid one cycle after fall, o_peak=9, o_peak_time=102, o_count=4.
REQ-037 Samples 7, 7, 7 at i_ctr 10, 11, 12 -> o_peak=7, o_peak_time=10 (tie keeps earliest).
REQ-038 All samples -32768 -> o_peak=-32768, o_count equals the number of strobes.
REQ-039 Window with i_ce never high -> no o_valid; state back to IDLE.
REQ-040 Result held with i_ready=0, then a second window rises -> o_drop pulses 1 cycle; first result is unchanged; after i_ready, no result appears for the second window.
REQ-041 i_ready and rise in the same cycle -> transfer completes and the new window is tracked; 300 strobes in one window -> o_count=255; i_nrst low mid-TRACK -> all outputs 0 and no o_valid afterwards.
